level_controller: RTL and testbench
===================================

// Module: level_controller
// PURPOSE
//  Game-progress FSM of the memory game; sits directly upstream of the level decoder.
//  Counts cleared rounds, advances the 2-bit level code 01->10->11, holds a
//    pause between levels, and flags win/loss.
//  The level output drives the decoder's level input unchanged (00 = no level active).
// PARAMETERS
//  ROUNDS_PER_LEVEL  3            rounds to clear per level; range 1..15
//  PAUSE_CYCLES      100_000_000  inter-level pause length in clk cycles (1 s @100 MHz); >=1
//  LIVES             3            retries per game when LIVES_EN is defined; range 1..3
// PORTS
//  clk         in   1  system clock, rising edge
//  reset_n     in   1  asynchronous, active-low reset
//  start       in   1  1-cycle pulse: begin or restart a game
//  round_ok    in   1  1-cycle pulse: player reproduced the current sequence
//  round_fail  in   1  1-cycle pulse: player made a mistake
//  level       out  2  00 idle, 01/10/11 = level 1/2/3; feeds decoder
//  round_idx   out  4  rounds cleared in current level, 0..ROUNDS_PER_LEVEL-1
//  busy        out  1  high during inter-level pause; inputs ignored
//  game_won    out  1  held high after level 3 is cleared
//  game_over   out  1  held high after a loss
//  lives       out  2  remaining lives (constant 0 without LIVES_EN)
// BEHAVIOUR
//  - All outputs registered; reset_n low forces immediately (no clk edge):
//      state=IDLE, level=00, round_idx=0, busy=0, game_won=0, game_over=0,
//      lives=0, pause counter=0.
//  - States: IDLE, PLAY, PAUSE, WON, LOST.
//  - IDLE/WON/LOST + start -> PLAY
//      - level=01, round_idx=0, flags cleared, lives=LIVES (if LIVES_EN).
//      - Visible on the cycle after start is sampled.
//  - PLAY + round_ok, round_idx < ROUNDS_PER_LEVEL-1: round_idx+1, stay in PLAY.
//  - PLAY + round_ok, round_idx == ROUNDS_PER_LEVEL-1:
//      - level 01/10: level+1, round_idx=0, -> PAUSE, counter loaded PAUSE_CYCLES-1.
//      - level 11: -> WON, game_won=1; level holds 11 (never wraps).
//  - PLAY + round_fail -> LOST, game_over=1; level/round_idx hold their values.
//  - round_ok and round_fail in the same cycle: round_fail wins.
//  - start in PLAY or PAUSE: ignored.
//  - PAUSE:
//      - busy=1 for exactly PAUSE_CYCLES cycles.
//      - counter decrements each cycle; at 0 -> PLAY, busy=0.
//      - round_ok/round_fail ignored.
//  - WON/LOST: ignore round_ok/round_fail; only start or reset leaves.
//  - level is 00 only in IDLE (after reset).
//  - Pause counter width = $clog2(PAUSE_CYCLES+1).
// CONFIGURATION
//  LEVEL_CTRL_LIVES_EN defined:
//    - PLAY + round_fail with lives>1: lives-1, round_idx=0, level unchanged,
//      -> PAUSE (full PAUSE_CYCLES).
//    - PLAY + round_fail with lives==1: lives=0, -> LOST, game_over=1.
//  LEVEL_CTRL_LIVES_EN undefined:
//    - no lives register; lives tied 0; any round_fail -> LOST immediately.
// TESTING (bench params: ROUNDS_PER_LEVEL=2, PAUSE_CYCLES=4, LIVES=2)
//  1. Release reset_n, pulse start
//     -> next cycle level=01, round_idx=0, busy=0, game_won=0, game_over=0.
//  2. Two round_ok pulses
//     -> after 2nd: level=10, round_idx=0, busy=1 for exactly 4 cycles;
//        round_ok during busy changes nothing.
//  3. Six round_ok (waiting out pauses) -> game_won=1, level=11;
//     then start -> level=01, game_won=0.
//  4. No macro, at level 10: round_ok and round_fail in the same cycle
//     -> game_over=1, level=10, round_idx unchanged.
//  5. LIVES_EN: start -> lives=2; round_fail -> lives=1, round_idx=0, busy 4 cycles;
//     round_fail again -> lives=0, game_over=1.
//  6. Assert reset_n mid-PAUSE between clk edges
//     -> level=00, busy=0, all flags 0 without waiting for a clk edge.

Source files
------------

// File: rtl/level_controller.sv
// Game-progress FSM for the memory game: counts cleared rounds, steps level 01->10->11, pauses between levels, flags win/loss.
// Latency: every output is registered and updates on the clock edge after the input pulse that caused the change.
// Backpressure: none; while busy (pause), WON or LOST, round_ok/round_fail are dropped and start is only honoured outside PLAY/PAUSE.
//
// Ports:
//   clk, reset_n                       clock (rising edge) and asynchronous active-low reset
//   start, round_ok, round_fail        1-cycle input pulses from the game logic
//   level[1:0]                         00 idle, 01/10/11 = level 1/2/3 (drives the level decoder directly)
//   round_idx[3:0]                     rounds cleared in the current level
//   busy                               high for exactly PAUSE_CYCLES cycles in each inter-level / retry pause
//   game_won, game_over                sticky result flags, cleared by start
//   lives[1:0]                         remaining retries (tied to 0 unless LEVEL_CTRL_LIVES_EN is defined)
//
// Optional feature: define LEVEL_CTRL_LIVES_EN to give the player LIVES retries per game.
module level_controller #(
  parameter int ROUNDS_PER_LEVEL = 3,
  parameter int PAUSE_CYCLES     = 100_000_000,
  parameter int LIVES            = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       round_ok,
  input  logic       round_fail,
  output logic [1:0] level,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       game_won,
  output logic       game_over,
  output logic [1:0] lives
);

  localparam int                 CNT_W      = $clog2(PAUSE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [3:0]         LAST_ROUND = 4'(ROUNDS_PER_LEVEL - 1);

  // Elaboration-time parameter range check.
  if (ROUNDS_PER_LEVEL < 1 || ROUNDS_PER_LEVEL > 15 || PAUSE_CYCLES < 1 ||
      LIVES < 1 || LIVES > 3) begin : g_bad_param
    $error("level_controller: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_PAUSE,
    S_WON,
    S_LOST
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       level_q, level_d;
  logic [3:0]       round_idx_q, round_idx_d;
  logic             busy_q, busy_d;
  logic             game_won_q, game_won_d;
  logic             game_over_q, game_over_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef LEVEL_CTRL_LIVES_EN
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  logic [1:0] lives_q, lives_d;
`endif

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    round_idx_d = round_idx_q;
    busy_d      = busy_q;
    game_won_d  = game_won_q;
    game_over_d = game_over_q;
    cnt_d       = cnt_q;
`ifdef LEVEL_CTRL_LIVES_EN
    lives_d     = lives_q;
`endif

    case (state_q)
      S_IDLE, S_WON, S_LOST: begin
        if (start) begin
          state_d     = S_PLAY;
          level_d     = 2'b01;
          round_idx_d = 4'd0;
          busy_d      = 1'b0;
          game_won_d  = 1'b0;
          game_over_d = 1'b0;
`ifdef LEVEL_CTRL_LIVES_EN
          lives_d     = LIVES_INIT;
`endif
        end
      end

      S_PLAY: begin
        // round_fail is checked first so it wins over a simultaneous round_ok.
        if (round_fail) begin
`ifdef LEVEL_CTRL_LIVES_EN
          if (lives_q > 2'd1) begin
            // Retry the same level from its first round after a full pause.
            lives_d     = lives_q - 2'd1;
            round_idx_d = 4'd0;
            state_d     = S_PAUSE;
            busy_d      = 1'b1;
            cnt_d       = PAUSE_LOAD;
          end else begin
            lives_d     = 2'd0;
            state_d     = S_LOST;
            game_over_d = 1'b1;
          end
`else
          state_d     = S_LOST;
          game_over_d = 1'b1;
`endif
        end else if (round_ok) begin
          if (round_idx_q == LAST_ROUND) begin
            if (level_q == 2'b11) begin
              // Final level cleared: level and round_idx freeze at their last values.
              state_d    = S_WON;
              game_won_d = 1'b1;
            end else begin
              level_d     = level_q + 2'd1;
              round_idx_d = 4'd0;
              state_d     = S_PAUSE;
              busy_d      = 1'b1;
              cnt_d       = PAUSE_LOAD;
            end
          end else begin
            round_idx_d = round_idx_q + 4'd1;
          end
        end
      end

      S_PAUSE: begin
        // Counter is loaded with PAUSE_CYCLES-1, so busy covers count values
        // PAUSE_CYCLES-1 down to 0: exactly PAUSE_CYCLES cycles.
        if (cnt_q == '0) begin
          state_d = S_PLAY;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      level_q     <= 2'b00;
      round_idx_q <= 4'd0;
      busy_q      <= 1'b0;
      game_won_q  <= 1'b0;
      game_over_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      round_idx_q <= round_idx_d;
      busy_q      <= busy_d;
      game_won_q  <= game_won_d;
      game_over_q <= game_over_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef LEVEL_CTRL_LIVES_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lives_q <= 2'd0;
    end else begin
      lives_q <= lives_d;
    end
  end

  assign lives = lives_q;
`else
  assign lives = 2'd0;
`endif

  assign level     = level_q;
  assign round_idx = round_idx_q;
  assign busy      = busy_q;
  assign game_won  = game_won_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_level_controller.sv
// Directed table-driven bench for level_controller (ROUNDS_PER_LEVEL=2, PAUSE_CYCLES=4, LIVES=2).
// Each table row is one clock of input pulses followed by the expected registered outputs.
// Hand-written sequences cover reset state and asynchronous reset in the middle of a pause.
module tb_level_controller;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       round_ok;
  logic       round_fail;
  logic [1:0] level;
  logic [3:0] round_idx;
  logic       busy;
  logic       game_won;
  logic       game_over;
  logic [1:0] lives;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef LEVEL_CTRL_LIVES_EN
  localparam logic [1:0] LV = 2'd2;
`else
  localparam logic [1:0] LV = 2'd0;
`endif

  level_controller #(
    .ROUNDS_PER_LEVEL(2),
    .PAUSE_CYCLES    (4),
    .LIVES           (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .round_ok  (round_ok),
    .round_fail(round_fail),
    .level     (level),
    .round_idx (round_idx),
    .busy      (busy),
    .game_won  (game_won),
    .game_over (game_over),
    .lives     (lives)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       ok;
    logic       fl;
    logic [1:0] lv;
    logic [3:0] ix;
    logic       b;
    logic       w;
    logic       o;
    logic [1:0] lf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic s, input logic ok, input logic fl,
                              input logic [1:0] lv, input logic [3:0] ix,
                              input logic b, input logic w, input logic o,
                              input logic [1:0] lf);
    vec_t v;
    v.s = s; v.ok = ok; v.fl = fl;
    v.lv = lv; v.ix = ix; v.b = b; v.w = w; v.o = o; v.lf = lf;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] lv, input logic [3:0] ix,
                           input logic b, input logic w, input logic o, input logic [1:0] lf);
    check({tag, ".level"},     {2'b00, level}, {2'b00, lv});
    check({tag, ".round_idx"}, round_idx,      ix);
    check({tag, ".busy"},      {3'b000, busy}, {3'b000, b});
    check({tag, ".game_won"},  {3'b000, game_won},  {3'b000, w});
    check({tag, ".game_over"}, {3'b000, game_over}, {3'b000, o});
    check({tag, ".lives"},     {2'b00, lives}, {2'b00, lf});
  endtask

  // One clock with the given pulses; returns 1 time unit after the sampling edge.
  task automatic step(input logic s, input logic ok, input logic fl);
    start = s; round_ok = ok; round_fail = fl;
    @(posedge clk);
    #1;
    start = 1'b0; round_ok = 1'b0; round_fail = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // start ok fl | level idx busy won over lives
    add(1,0,0, 2'd1,4'd0,0,0,0,LV);  // 0  start -> level 1
    add(0,1,0, 2'd1,4'd1,0,0,0,LV);  // 1
    add(0,1,0, 2'd2,4'd0,1,0,0,LV);  // 2  level 2, pause cycle 1
    add(0,1,0, 2'd2,4'd0,1,0,0,LV);  // 3  round_ok ignored in pause
    add(0,0,1, 2'd2,4'd0,1,0,0,LV);  // 4  round_fail ignored in pause
    add(1,0,0, 2'd2,4'd0,1,0,0,LV);  // 5  start ignored, pause cycle 4
    add(0,0,0, 2'd2,4'd0,0,0,0,LV);  // 6  pause over
    add(0,1,0, 2'd2,4'd1,0,0,0,LV);  // 7
    add(0,1,0, 2'd3,4'd0,1,0,0,LV);  // 8  level 3, pause
    add(0,0,0, 2'd3,4'd0,1,0,0,LV);  // 9
    add(0,0,0, 2'd3,4'd0,1,0,0,LV);  // 10
    add(0,0,0, 2'd3,4'd0,1,0,0,LV);  // 11
    add(0,0,0, 2'd3,4'd0,0,0,0,LV);  // 12
    add(0,1,0, 2'd3,4'd1,0,0,0,LV);  // 13
    add(0,1,0, 2'd3,4'd1,0,1,0,LV);  // 14 won, level stays 11
    add(0,1,0, 2'd3,4'd1,0,1,0,LV);  // 15 ignored in WON
    add(0,0,1, 2'd3,4'd1,0,1,0,LV);  // 16 ignored in WON
    add(1,0,0, 2'd1,4'd0,0,0,0,LV);  // 17 restart
    add(0,1,0, 2'd1,4'd1,0,0,0,LV);  // 18
    add(0,1,0, 2'd2,4'd0,1,0,0,LV);  // 19
    add(0,0,0, 2'd2,4'd0,1,0,0,LV);  // 20
    add(0,0,0, 2'd2,4'd0,1,0,0,LV);  // 21
    add(0,0,0, 2'd2,4'd0,1,0,0,LV);  // 22
    add(0,0,0, 2'd2,4'd0,0,0,0,LV);  // 23
    add(0,1,0, 2'd2,4'd1,0,0,0,LV);  // 24
`ifdef LEVEL_CTRL_LIVES_EN
    add(0,1,1, 2'd2,4'd0,1,0,0,2'd1); // 25 fail wins: lose a life, retry pause
    add(0,0,0, 2'd2,4'd0,1,0,0,2'd1);
    add(0,0,0, 2'd2,4'd0,1,0,0,2'd1);
    add(0,0,0, 2'd2,4'd0,1,0,0,2'd1);
    add(0,0,0, 2'd2,4'd0,0,0,0,2'd1);
    add(0,0,1, 2'd2,4'd0,0,0,1,2'd0); // 30 last life gone
    add(1,0,0, 2'd1,4'd0,0,0,0,2'd2); // 31 start restores lives
    add(0,0,1, 2'd1,4'd0,1,0,0,2'd1); // 32
    add(0,0,0, 2'd1,4'd0,1,0,0,2'd1);
    add(0,0,0, 2'd1,4'd0,1,0,0,2'd1);
    add(0,0,0, 2'd1,4'd0,1,0,0,2'd1);
    add(0,0,0, 2'd1,4'd0,0,0,0,2'd1);
    add(0,0,1, 2'd1,4'd0,0,0,1,2'd0); // 37 game over
`else
    add(0,1,1, 2'd2,4'd1,0,0,1,2'd0); // 25 fail wins: lost, level/idx hold
    add(0,1,0, 2'd2,4'd1,0,0,1,2'd0); // 26 ignored in LOST
    add(1,0,0, 2'd1,4'd0,0,0,0,2'd0); // 27 restart clears game_over
`endif

    start = 1'b0; round_ok = 1'b0; round_fail = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 2'd0, 4'd0, 0, 0, 0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].ok, tbl[i].fl);
      check_all($sformatf("v%0d", i), tbl[i].lv, tbl[i].ix, tbl[i].b, tbl[i].w, tbl[i].o, tbl[i].lf);
    end

    // Asynchronous reset between clock edges while paused.
    if (game_over) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check_all("pre_arst", 2'd2, 4'd0, 1, 0, 0, LV);
    #2;
    reset_n = 1'b0;
    #1;  // well before the next rising edge
    check_all("arst", 2'd0, 4'd0, 0, 0, 0, 2'd0);
    @(posedge clk);
    #1;
    check_all("arst_hold", 2'd0, 4'd0, 0, 0, 0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 1, 0);
    check_all("idle_ok", 2'd0, 4'd0, 0, 0, 0, 2'd0);
    step(0, 0, 1);
    check_all("idle_fail", 2'd0, 4'd0, 0, 0, 0, 2'd0);
    step(1, 0, 0);
    check_all("post_arst_start", 2'd1, 4'd0, 0, 0, 0, LV);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
